// File: rtl/spi_nand_pkg.sv
// Shared definitions for the SPI-NAND command sequencer.
// Holds the flash opcodes, the host command encoding, the sequencer state
// encoding and the helper that picks the byte to transmit for a given
// position inside a transaction.
package spi_nand_pkg;

    // Flash opcodes and the status feature address
    localparam logic [7:0] OpcReadId     = 8'h9F;
    localparam logic [7:0] OpcGetFeature = 8'h0F;
    localparam logic [7:0] OpcPageRead   = 8'h13;
    localparam logic [7:0] OpcReadCache  = 8'h03;
    localparam logic [7:0] FeatStatus    = 8'hC0;

    // Host command encoding on i_Cmd_Op
    typedef enum logic [1:0] {
        CmdReadId    = 2'd0,
        CmdGetStatus = 2'd1,
        CmdPageRead  = 2'd2,
        CmdReadCache = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCsLow  = 3'd1,
        StSend   = 3'd2,
        StWaitRx = 3'd3,
        StCsHigh = 3'd4,
        StGap    = 3'd5
    } state_e;

    // Byte to send at position idx. status_xfer selects the GET_FEATURE(C0)
    // framing used both by GET_STATUS and by PAGE_READ polls. Positions past
    // the header (dummy / data clocking) are always 00.
    function automatic logic [7:0] tx_byte_for(cmd_op_e     op,
                                               logic        status_xfer,
                                               logic [2:0]  idx,
                                               logic [23:0] row,
                                               logic [15:0] col);
        logic [7:0] b;
        b = 8'h00;
        if (status_xfer) begin
            if (idx == 3'd0)      b = OpcGetFeature;
            else if (idx == 3'd1) b = FeatStatus;
        end else begin
            case (op)
                CmdReadId: begin
                    if (idx == 3'd0) b = OpcReadId;
                end
                CmdPageRead: begin
                    case (idx)
                        3'd0:    b = OpcPageRead;
                        3'd1:    b = row[23:16];
                        3'd2:    b = row[15:8];
                        3'd3:    b = row[7:0];
                        default: b = 8'h00;
                    endcase
                end
                CmdReadCache: begin
                    case (idx)
                        3'd0:    b = OpcReadCache;
                        3'd1:    b = col[15:8];
                        3'd2:    b = col[7:0];
                        default: b = 8'h00;
                    endcase
                end
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/spi_nand_cmd_seq.sv
// SPI-NAND command sequencer.
// Turns host commands (READ_ID, GET_STATUS, PAGE_READ, READ_CACHE) into byte
// streams for a byte-oriented SPI master, frames each transaction with chip
// select, polls the status register after PAGE_READ, and returns data bytes.
// Ports:
//   i_Clk, i_Rst_L                 clock, async active-low reset
//   i_Cmd_Valid/o_Cmd_Ready        command handshake
//   i_Cmd_Op/i_Row_Addr/i_Col_Addr/i_Len  command fields (latched on accept)
//   o_Data/o_Data_Valid            returned bytes
//   o_Done/o_Timeout               completion pulse, PAGE_READ poll timeout
//   o_SPI_CS_n                     flash chip select
//   o_TX_Byte/o_TX_DV/i_TX_Ready   byte to SPI master
//   i_RX_DV/i_RX_Byte              byte from SPI master
module spi_nand_cmd_seq
    import spi_nand_pkg::*;
#(
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_IDLE    = 4,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Cmd_Valid,
    output logic        o_Cmd_Ready,
    input  logic [1:0]  i_Cmd_Op,
    input  logic [23:0] i_Row_Addr,
    input  logic [15:0] i_Col_Addr,
    input  logic [11:0] i_Len,
    output logic [7:0]  o_Data,
    output logic        o_Data_Valid,
    output logic        o_Done,
    output logic        o_Timeout,
    output logic        o_SPI_CS_n,
    output logic [7:0]  o_TX_Byte,
    output logic        o_TX_DV,
    input  logic        i_TX_Ready,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte
);

    localparam int unsigned WaitMax = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
    localparam int unsigned WaitW   = $clog2(WaitMax + 1);
    localparam int unsigned PollW   = $clog2(POLL_LIMIT + 1);

    state_e             state_q;
    cmd_op_e            op_q;
    logic [23:0]        row_q;
    logic [15:0]        col_q;
    logic [11:0]        len_cnt_q;   // data bytes left; 0 means 4096
    logic [2:0]         idx_q;       // byte position in transaction, sticks at 4
    logic               poll_q;      // PAGE_READ is in its status-poll phase
    logic [PollW-1:0]   poll_cnt_q;
    logic [7:0]         status_q;
    logic [WaitW-1:0]   wait_q;

    logic               cmd_ready_q;
    logic [7:0]         data_q;
    logic               data_valid_q;
    logic               done_q;
    logic               timeout_q;
    logic               cs_n_q;
    logic [7:0]         tx_byte_q;

    logic status_xfer;
    logic last_byte;
    logic return_byte;
    logic setup_met;
    logic idle_met;
    logic poll_more;

    always_comb begin
        status_xfer = poll_q || (op_q == CmdGetStatus);
        last_byte   = 1'b0;
        return_byte = 1'b0;
        if (status_xfer) begin
            last_byte   = (idx_q == 3'd2);
            return_byte = !poll_q && (idx_q == 3'd2);
        end else begin
            case (op_q)
                CmdReadId: begin
                    last_byte   = (idx_q == 3'd3);
                    return_byte = (idx_q >= 3'd2);
                end
                CmdPageRead: begin
                    last_byte = (idx_q == 3'd3);
                end
                CmdReadCache: begin
                    last_byte   = (idx_q == 3'd4) && (len_cnt_q == 12'd1);
                    return_byte = (idx_q == 3'd4);
                end
                default: begin
                    last_byte   = 1'b0;
                    return_byte = 1'b0;
                end
            endcase
        end
        setup_met = (32'(wait_q) + 32'd1) >= CS_SETUP;
        idle_met  = (32'(wait_q) + 32'd1) >= CS_IDLE;
        poll_more = 32'(poll_cnt_q) < POLL_LIMIT;
    end

    // Strobe is qualified by ready so a held-off SEND never issues a byte.
    assign o_TX_DV      = (state_q == StSend) && i_TX_Ready;
    assign o_TX_Byte    = tx_byte_q;
    assign o_SPI_CS_n   = cs_n_q;
    assign o_Cmd_Ready  = cmd_ready_q;
    assign o_Data       = data_q;
    assign o_Data_Valid = data_valid_q;
    assign o_Done       = done_q;
    assign o_Timeout    = timeout_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= StIdle;
            op_q         <= CmdReadId;
            row_q        <= '0;
            col_q        <= '0;
            len_cnt_q    <= '0;
            idx_q        <= '0;
            poll_q       <= 1'b0;
            poll_cnt_q   <= '0;
            status_q     <= '0;
            wait_q       <= '0;
            cmd_ready_q  <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cs_n_q       <= 1'b1;
            tx_byte_q    <= '0;
        end else begin
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (i_Cmd_Valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op_e'(i_Cmd_Op);
                        row_q       <= i_Row_Addr;
                        col_q       <= i_Col_Addr;
                        len_cnt_q   <= i_Len;
                        poll_q      <= 1'b0;
                        poll_cnt_q  <= '0;
                        idx_q       <= '0;
                        wait_q      <= '0;
                        cs_n_q      <= 1'b0;
                        state_q     <= StCsLow;
                    end
                end
                StCsLow: begin
                    if (setup_met) begin
                        tx_byte_q <= tx_byte_for(op_q, status_xfer, 3'd0, row_q, col_q);
                        state_q   <= StSend;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StSend: begin
                    if (i_TX_Ready) state_q <= StWaitRx;
                end
                StWaitRx: begin
                    if (i_RX_DV) begin
                        if (return_byte) begin
                            data_q       <= i_RX_Byte;
                            data_valid_q <= 1'b1;
                        end
                        if (status_xfer && (idx_q == 3'd2)) status_q <= i_RX_Byte;
                        if ((op_q == CmdReadCache) && (idx_q == 3'd4)) begin
                            len_cnt_q <= len_cnt_q - 12'd1;
                        end
                        if (idx_q != 3'd4) idx_q <= idx_q + 3'd1;
                        if (last_byte) begin
                            if (poll_q && poll_more) poll_cnt_q <= poll_cnt_q + PollW'(1);
                            wait_q  <= '0;
                            state_q <= StCsHigh;
                        end else begin
                            tx_byte_q <= tx_byte_for(op_q, status_xfer, idx_q + 3'd1,
                                                     row_q, col_q);
                            state_q   <= StSend;
                        end
                    end
                end
                StCsHigh: begin
                    if (setup_met) begin
                        cs_n_q  <= 1'b1;
                        wait_q  <= '0;
                        state_q <= StGap;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StGap: begin
                    if (idle_met) begin
                        wait_q <= '0;
                        if ((op_q == CmdPageRead) && !poll_q) begin
                            // PAGE_READ command sent: start polling OIP
                            poll_q  <= 1'b1;
                            idx_q   <= '0;
                            cs_n_q  <= 1'b0;
                            state_q <= StCsLow;
                        end else if (poll_q && status_q[0] && poll_more) begin
                            idx_q   <= '0;
                            cs_n_q  <= 1'b0;
                            state_q <= StCsLow;
                        end else begin
                            done_q    <= 1'b1;
                            timeout_q <= poll_q && status_q[0];
                            state_q   <= StIdle;
                        end
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_nand_cmd_seq.sv
// Directed bench for spi_nand_cmd_seq: a combined SPI-master/flash model
// answers each TX byte after a fixed latency, and scoreboard queues hold the
// expected TX and data streams pushed before each command is issued.
module tb_spi_nand_cmd_seq;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op    = 2'd0;
    logic [23:0] row       = '0;
    logic [15:0] col       = '0;
    logic [11:0] len       = '0;
    logic [7:0]  data;
    logic        data_valid;
    logic        done;
    logic        timeout;
    logic        cs_n;
    logic [7:0]  tx_byte;
    logic        tx_dv;
    logic        tx_ready  = 1'b1;
    logic        rx_dv     = 1'b0;
    logic [7:0]  rx_byte   = '0;

    int          n_asserts = 0;
    int          n_fails   = 0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_data[$];
    int          done_cnt     = 0;
    logic        last_timeout = 1'b0;
    int          data_seen    = 0;
    int          status_reads = 0;
    int          oip_polls    = 0;   // status reads reporting busy; <0 = stuck busy
    int          bp_len       = 0;
    bit          bp_used      = 1'b0;

    always #5 clk = ~clk;

    spi_nand_cmd_seq #(
        .CS_SETUP  (2),
        .CS_IDLE   (4),
        .POLL_LIMIT(8)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Cmd_Valid (cmd_valid),
        .o_Cmd_Ready (cmd_ready),
        .i_Cmd_Op    (cmd_op),
        .i_Row_Addr  (row),
        .i_Col_Addr  (col),
        .i_Len       (len),
        .o_Data      (data),
        .o_Data_Valid(data_valid),
        .o_Done      (done),
        .o_Timeout   (timeout),
        .o_SPI_CS_n  (cs_n),
        .o_TX_Byte   (tx_byte),
        .o_TX_DV     (tx_dv),
        .i_TX_Ready  (tx_ready),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic extra(input string tag, input logic [7:0] obs);
        n_asserts++;
        n_fails++;
        $error("FAIL %s: observed %0h expected nothing", tag, obs);
    endtask

    // SPI master + flash model and output monitor. Inputs change just after
    // the falling edge, outputs are sampled 1 time unit later.
    initial begin : flash_model
        int         busy = 0;
        int         bp_cnt = 0;
        int         fl_idx = 0;
        int         high_len = 100;
        int         setup_len = 0;
        bit         seen_tx = 1'b0;
        logic       prev_cs = 1'b1;
        logic [7:0] fl_opc = 8'h00;
        logic [7:0] pend = 8'h00;
        logic [7:0] resp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0; bp_cnt = 0; fl_idx = 0; rx_dv = 1'b0; tx_ready = 1'b1;
                prev_cs = 1'b1; high_len = 100; seen_tx = 1'b0;
                continue;
            end
            rx_dv = 1'b0;
            if (bp_cnt > 0) bp_cnt--;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    rx_dv   = 1'b1;
                    rx_byte = pend;
                    if (fl_opc == 8'h03 && fl_idx == 2 && bp_len > 0 && !bp_used) begin
                        bp_cnt  = bp_len;
                        bp_used = 1'b1;
                    end
                end
            end
            tx_ready = (busy == 0) && (bp_cnt == 0);
            #1;
            if (cs_n == 1'b0 && prev_cs == 1'b1) begin
                check("cs_high_gap", 32'(high_len >= 4), 1);
                fl_idx = 0; setup_len = 0; seen_tx = 1'b0;
            end
            if (cs_n) high_len++;
            else begin
                high_len = 0;
                if (!seen_tx && !tx_dv) setup_len++;
            end
            prev_cs = cs_n;
            if (tx_dv) begin
                check("tx_cs_low", cs_n, 0);
                check("tx_ready", tx_ready, 1);
                if (!seen_tx) begin
                    check("cs_setup", setup_len, 2);
                    seen_tx = 1'b1;
                end
                if (exp_tx.size() == 0) extra("tx_extra_byte", tx_byte);
                else check("tx_byte", tx_byte, exp_tx.pop_front());
                if (fl_idx == 0) begin
                    fl_opc = tx_byte;
                    if (tx_byte == 8'h0F) status_reads++;
                    if (tx_byte == 8'h13) status_reads = 0;
                end
                resp = 8'h5A;
                case (fl_opc)
                    8'h9F: if (fl_idx == 2) resp = 8'h2C; else if (fl_idx == 3) resp = 8'h24;
                    8'h0F: if (fl_idx == 2)
                               resp = (oip_polls < 0 || status_reads <= oip_polls) ? 8'hA1 : 8'hA0;
                    8'h03: if (fl_idx >= 4) resp = 8'hA0 + 8'(fl_idx - 4);
                    default: resp = 8'h5A;
                endcase
                pend = resp;
                fl_idx++;
                busy = 3;
            end
            if (data_valid) begin
                data_seen++;
                if (exp_data.size() == 0) extra("data_extra_byte", data);
                else check("data_byte", data, exp_data.pop_front());
            end
            if (done) begin
                done_cnt++;
                last_timeout = timeout;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [23:0] r, input logic [15:0] c,
                         input logic [11:0] l);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #2; n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_op = op; row = r; col = c; len = l; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        // Scramble fields: the DUT must work from its latched copy.
        cmd_op = 2'($urandom); row = 24'($urandom); col = 16'($urandom); len = 12'($urandom);
        check("accept_ready_low", cmd_ready, 0);
        check("accept_cs_low", cs_n, 0);
    endtask

    task automatic wait_done(input string tag, input logic exp_to, input int budget);
        int start = done_cnt;
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #2;
            if (done_cnt != start) got = 1'b1;
        end
        check({tag, "_done"}, 32'(got), 1);
        check({tag, "_timeout"}, last_timeout, exp_to);
        check({tag, "_ready_with_done"}, cmd_ready, 0);
        check({tag, "_txq_empty"}, exp_tx.size(), 0);
        check({tag, "_dataq_empty"}, exp_data.size(), 0);
        @(negedge clk); #2;
        check({tag, "_ready_after_done"}, cmd_ready, 1);
        check({tag, "_single_done"}, done_cnt, start + 1);
    endtask

    task automatic push_status_polls(input int n);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(8'h0F); exp_tx.push_back(8'hC0); exp_tx.push_back(8'h00);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, cs_n, 1);
        check({tag, "_tx_dv"}, tx_dv, 0);
        check({tag, "_tx_byte"}, tx_byte, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int start;
        int n;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge", cmd_ready, 0);
        @(posedge clk); #1 check("ready_after_reset", cmd_ready, 1);

        // READ_ID
        exp_tx   = '{8'h9F, 8'h00, 8'h00, 8'h00};
        exp_data = '{8'h2C, 8'h24};
        issue(2'd0, 24'h0, 16'h0, 12'h0);
        wait_done("read_id", 1'b0, 200);

        // GET_STATUS, flash ready
        oip_polls = 0;
        exp_tx    = '{8'h0F, 8'hC0, 8'h00};
        exp_data  = '{8'hA0};
        issue(2'd1, 24'h0, 16'h0, 12'h0);
        wait_done("get_status", 1'b0, 200);

        // PAGE_READ, busy for 3 polls
        oip_polls = 3;
        exp_tx    = '{8'h13, 8'h01, 8'h23, 8'h45};
        push_status_polls(4);
        issue(2'd2, 24'h012345, 16'h0, 12'h0);
        wait_done("page_read", 1'b0, 1000);
        check("page_read_polls", status_reads, 4);

        // PAGE_READ, OIP stuck: POLL_LIMIT=8 polls then timeout
        oip_polls = -1;
        exp_tx    = '{8'h13, 8'hAB, 8'hCD, 8'hEF};
        push_status_polls(8);
        issue(2'd2, 24'hABCDEF, 16'h0, 12'h0);
        wait_done("page_timeout", 1'b1, 2000);
        check("page_timeout_polls", status_reads, 8);

        // READ_CACHE with 20 cycles of TX backpressure mid-header
        bp_len   = 20;
        exp_tx   = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        issue(2'd3, 24'h0, 16'h0010, 12'd5);
        wait_done("read_cache", 1'b0, 500);
        check("backpressure_applied", 32'(bp_used), 1);

        // READ_CACHE len=0 transfers 4096 bytes
        exp_tx = '{8'h03, 8'h12, 8'h34, 8'h00};
        for (int i = 0; i < 4096; i++) begin
            exp_tx.push_back(8'h00);
            exp_data.push_back(8'hA0 + 8'(i));
        end
        start = data_seen;
        issue(2'd3, 24'h0, 16'h1234, 12'd0);
        wait_done("read_cache_4096", 1'b0, 20000);
        check("read_cache_4096_count", data_seen - start, 4096);

        // Reset in the middle of READ_CACHE, after the 2nd data byte
        exp_tx = '{8'h03, 8'h00, 8'h20, 8'h00};
        for (int i = 0; i < 10; i++) begin
            exp_tx.push_back(8'h00);
            exp_data.push_back(8'hA0 + 8'(i));
        end
        start = data_seen;
        issue(2'd3, 24'h0, 16'h0020, 12'd10);
        n = 0;
        while (data_seen < start + 2 && n < 500) begin
            @(negedge clk); #2; n++;
        end
        check("mid_reset_reached", 32'(data_seen - start >= 2), 1);
        start = done_cnt;
        #1 rst_n = 1'b0;
        #1 check("mid_reset_cs_n", cs_n, 1);
        check("mid_reset_tx_dv", tx_dv, 0);
        check("mid_reset_data_valid", data_valid, 0);
        check("mid_reset_ready", cmd_ready, 0);
        exp_tx.delete();
        exp_data.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_reset_ready_before_edge", cmd_ready, 0);
        @(posedge clk); #1 check("mid_reset_ready_after", cmd_ready, 1);
        check("mid_reset_no_done", done_cnt, start);

        // Recovery after reset
        exp_tx   = '{8'h9F, 8'h00, 8'h00, 8'h00};
        exp_data = '{8'h2C, 8'h24};
        issue(2'd0, 24'h0, 16'h0, 12'h0);
        wait_done("read_id_after_reset", 1'b0, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/spi_nand_cmd_seq.md
SPI_NAND_CMD_SEQ -- requirements
Module: spi_nand_cmd_seq

Interface
REQ-001 SHALL have parameter CS_SETUP, default 2: idle cycles between CS_n fall and the first TX_DV, and between the last RX_DV and CS_n rise.
REQ-002 SHALL have parameter CS_IDLE, default 4: minimum cycles CS_n stays high between transactions.
REQ-003 SHALL have parameter POLL_LIMIT, default 1024: maximum status polls per PAGE_READ.
REQ-004 SHALL have port i_Clk, input, 1: sole clock.
REQ-005 SHALL have port i_Rst_L, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_Cmd_Valid, input, 1: command request.
REQ-007 SHALL have port o_Cmd_Ready, output, 1: sequencer idle; a command is accepted when valid and ready are both high.
REQ-008 SHALL have port i_Cmd_Op, input, 2: 0=READ_ID, 1=GET_STATUS, 2=PAGE_READ, 3=READ_CACHE.
REQ-009 SHALL have port i_Row_Addr, input, 24: row address for PAGE_READ.
REQ-010 SHALL have port i_Col_Addr, input, 16: column address for READ_CACHE.
REQ-011 SHALL have port i_Len, input, 12: byte count for READ_CACHE, 0 meaning 4096.
REQ-012 SHALL have port o_Data, output, 8: returned data byte.
REQ-013 SHALL have port o_Data_Valid, output, 1: one-cycle strobe qualifying o_Data.
REQ-014 SHALL have port o_Done, output, 1: one-cycle pulse at command completion.
REQ-015 SHALL have port o_Timeout, output, 1: qualifies o_Done; high when PAGE_READ exhausted POLL_LIMIT.
REQ-016 SHALL have port o_SPI_CS_n, output, 1: flash chip select.
REQ-017 SHALL have port o_TX_Byte, output, 8: byte to the SPI master.
REQ-018 SHALL have port o_TX_DV, output, 1: one-cycle strobe to the SPI master.
REQ-019 SHALL have port i_TX_Ready, input, 1: SPI master idle.
REQ-020 SHALL have port i_RX_DV, input, 1: SPI master byte-received strobe.
REQ-021 SHALL have port i_RX_Byte, input, 8: received byte from the SPI master.

Function
REQ-022 SHALL step through the states IDLE -> CS_LOW -> SEND -> WAIT_RX -> (SEND | CS_HIGH) -> GAP -> (IDLE | CS_LOW for poll).
REQ-023 SHALL assert o_TX_DV for exactly one cycle, only in SEND, and only while i_TX_Ready=1.
REQ-024 SHALL remain in WAIT_RX until i_RX_DV=1 and SHALL capture i_RX_Byte on that cycle.
REQ-025 SHALL issue one TX_DV per byte and never have a second TX_DV outstanding.
REQ-026 SHALL send READ_ID as 9F,00,00,00 and return received bytes 3..4 (MID, DID) on o_Data.
REQ-027 SHALL send GET_STATUS as 0F,C0,00 and return received byte 3.
REQ-028 SHALL handle PAGE_READ as follows:
- send 13 followed by row[23:16], row[15:8], row[7:0];
- then repeatedly run GET_STATUS, each poll separated by CS_IDLE;
- complete when status bit0 (OIP) = 0;
- after POLL_LIMIT polls with OIP=1, pulse o_Done with o_Timeout=1.
REQ-029 SHALL send READ_CACHE as 03, col[15:8], col[7:0], 00 (dummy), then i_Len bytes of 00, returning each received byte.
REQ-030 SHALL leave o_Data_Valid low for command, address and dummy bytes, and for PAGE_READ status polls.
REQ-031 SHALL drive o_SPI_CS_n low for the whole of each transaction and high otherwise.
REQ-032 SHALL pulse o_Done on the cycle GAP returns to IDLE, and SHALL raise o_Cmd_Ready on the following cycle.
REQ-033 SHALL latch the command fields at acceptance and ignore input changes until o_Done.
REQ-034 SHALL use a 12-bit byte counter that wraps 0->4095, so i_Len=0 transfers 4096 bytes.
REQ-035 SHALL use a poll counter of $clog2(POLL_LIMIT+1) bits that saturates and never wraps.

Reset
REQ-036 SHALL, while i_Rst_L=0, force the following immediately and asynchronously, even mid-transaction:
- o_SPI_CS_n=1, o_TX_DV=0, o_TX_Byte=00;
- o_Data=00, o_Data_Valid=0, o_Done=0, o_Timeout=0, o_Cmd_Ready=0;
- state=IDLE, all counters=0.
REQ-037 SHALL assert o_Cmd_Ready one cycle after i_Rst_L deasserts.
REQ-038 SHALL discard any i_RX_DV arriving after reset and before the first accepted command.

Structure
REQ-039 SHALL take opcode and state encodings from a shared package spi_nand_pkg, which holds:
- opcode constants 9F, 0F, 13, 03, C0;
- the i_Cmd_Op enum;
- the state enum.
REQ-040 SHALL be a single module with no sub-modules, connecting point-to-point to SPI_Master.

Verification
REQ-041 SHALL pass READ_ID: a flash model returns MID=2C, DID=24 -> TX stream 9F,00,00,00; o_Data 2C then 24; one o_Done.
REQ-042 SHALL pass PAGE_READ: row=0x012345, OIP=1 for 3 polls then 0 -> TX 13,01,23,45; 4 status transactions, each with CS high >=4 cycles between; o_Done with o_Timeout=0.
REQ-043 SHALL pass PAGE_READ timeout: POLL_LIMIT=8, OIP stuck at 1 -> exactly 8 polls; o_Done with o_Timeout=1.
REQ-044 SHALL pass READ_CACHE: col=0x0010, len=5, model returns A0..A4 -> TX 03,00,10,00,00x5; five o_Data_Valid strobes carrying A0..A4.
REQ-045 SHALL pass backpressure: i_TX_Ready held low for 20 cycles during SEND -> no o_TX_DV issued until ready; no byte lost.
REQ-046 SHALL pass reset mid-READ_CACHE: reset asserted after the 2nd data byte -> CS_n=1 asynchronously; no o_Done; o_Cmd_Ready=1 one cycle after release.
